// File: rtl/br_pkg.sv
// Shared types and constants for the branch-resolution stage.
package br_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned OP_W     = 3;

    // RISC-V conditional-branch funct3 encodings; 010/011 decode as illegal.
    typedef enum logic [OP_W-1:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_ILL  = 3'b010,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    // Registered result; redirect_pc is sized for the widest supported XLEN.
    typedef struct packed {
        logic                taken;
        logic                mispredict;
        logic                illegal;
        logic                less;
        logic                equal;
        logic [XLEN_MAX-1:0] redirect_pc;
    } br_res_t;

    // BLTU/BGEU compare unsigned, every other funct3 compares signed.
    function automatic logic br_is_unsigned(input logic [OP_W-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/br_resolve_if.sv
// Request/result bundle of the branch-resolution stage.
interface br_resolve_if
    import br_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = 16
);
    logic              valid_i;
    logic              ready_o;
    logic [OP_W-1:0]   br_op_i;
    logic [XLEN-1:0]   rs1_data_i;
    logic [XLEN-1:0]   rs2_data_i;
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   imm_i;
    logic              pred_taken_i;
    logic              flush_i;
    logic              clr_cnt_i;
    logic              valid_o;
    logic              ready_i;
    logic              taken_o;
    logic              mispredict_o;
    logic              illegal_o;
    logic              br_less_o;
    logic              br_equal_o;
    logic [XLEN-1:0]   redirect_pc_o;
    logic [CNT_W-1:0]  br_cnt_o;
    logic [CNT_W-1:0]  mis_cnt_o;

    modport slave (
        input  valid_i, br_op_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               pred_taken_i, flush_i, clr_cnt_i, ready_i,
        output ready_o, valid_o, taken_o, mispredict_o, illegal_o,
               br_less_o, br_equal_o, redirect_pc_o, br_cnt_o, mis_cnt_o
    );

    modport master (
        output valid_i, br_op_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               pred_taken_i, flush_i, clr_cnt_i, ready_i,
        input  ready_o, valid_o, taken_o, mispredict_o, illegal_o,
               br_less_o, br_equal_o, redirect_pc_o, br_cnt_o, mis_cnt_o
    );

endinterface

// File: rtl/br_cmp.sv
// Combinational XLEN-bit comparator with signed/unsigned select.
module br_cmp #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            unsigned_i,
    output logic            less_c_o,
    output logic            equal_c_o
);

    // Equality is sign-agnostic; less-than honours the select.
    always_comb begin
        equal_c_o = (rs1_i == rs2_i);
        if (unsigned_i) begin
            less_c_o = (rs1_i < rs2_i);
        end else begin
            less_c_o = ($signed(rs1_i) < $signed(rs2_i));
        end
    end

endmodule

// File: rtl/br_resolve.sv
// Branch resolution: compare, decode, target select, one-entry output
// register and saturating retire statistics.
module br_resolve
    import br_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    br_resolve_if.slave  bus
);

    logic             less_c;
    logic             equal_c;
    logic             taken_c;
    logic             illegal_c;
    logic             ready_c;
    logic             accept_c;
    logic             retire_c;
    logic [XLEN-1:0]  target_c;
    logic [XLEN-1:0]  fallthru_c;
    br_res_t          res_d, res_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] br_cnt_d, br_cnt_q;
    logic [CNT_W-1:0] mis_cnt_d, mis_cnt_q;
    logic             unused_redirect;

    br_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1_i      (bus.rs1_data_i),
        .rs2_i      (bus.rs2_data_i),
        .unsigned_i (br_is_unsigned(bus.br_op_i)),
        .less_c_o   (less_c),
        .equal_c_o  (equal_c)
    );

    // Both adders wrap modulo 2^XLEN.
    assign target_c   = bus.pc_i + bus.imm_i;
    assign fallthru_c = bus.pc_i + XLEN'(4);

    assign ready_c  = !valid_q || bus.ready_i;
    assign accept_c = bus.valid_i && ready_c && !bus.flush_i;
    assign retire_c = valid_q && bus.ready_i && !bus.flush_i;

    // funct3 decode to branch direction.
    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (bus.br_op_i)
            BR_BEQ:  taken_c = equal_c;
            BR_BNE:  taken_c = !equal_c;
            BR_BLT:  taken_c = less_c;
            BR_BGE:  taken_c = !less_c;
            BR_BLTU: taken_c = less_c;
            BR_BGEU: taken_c = !less_c;
            default: illegal_c = 1'b1;
        endcase
    end

    // Output-register next state: flush beats accept beats retire.
    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d           = 1'b1;
            res_d.taken       = taken_c;
            res_d.mispredict  = taken_c ^ bus.pred_taken_i;
            res_d.illegal     = illegal_c;
            res_d.less        = less_c;
            res_d.equal       = equal_c;
            res_d.redirect_pc = XLEN_MAX'(taken_c ? target_c : fallthru_c);
        end else if (retire_c) begin
            valid_d = 1'b0;
        end
    end

    // Saturating counters; clear wins over a same-cycle retire.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (bus.clr_cnt_i) begin
            br_cnt_d  = '0;
            mis_cnt_d = '0;
        end else if (retire_c) begin
            if (br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (res_q.mispredict && (mis_cnt_q != '1)) begin
                mis_cnt_d = mis_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            res_q     <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            res_q     <= res_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Upper redirect bits beyond XLEN are always zero.
    assign unused_redirect = ^res_q.redirect_pc;

    assign bus.ready_o       = ready_c;
    assign bus.valid_o       = valid_q;
    assign bus.taken_o       = res_q.taken;
    assign bus.mispredict_o  = res_q.mispredict;
    assign bus.illegal_o     = res_q.illegal;
    assign bus.br_less_o     = res_q.less;
    assign bus.br_equal_o    = res_q.equal;
    assign bus.redirect_pc_o = XLEN'(res_q.redirect_pc);
    assign bus.br_cnt_o      = br_cnt_q;
    assign bus.mis_cnt_o     = mis_cnt_q;

endmodule

// File: doc/br_resolve.md
# br_resolve

Parametrised branch-resolution stage for the RV32I core. It compares two XLEN-bit operands for any RISC-V conditional-branch funct3, computes the branch target and redirect PC, and flags mispredictions against the fetch prediction. Results are held in a one-entry valid/ready output register, and the block keeps saturating branch and mispredict counters. It sits at the end of execute, replacing the purely combinational comparator, and feeds the fetch redirect path and writeback.

## Interface
- XLEN, 32, operand/PC width (≥ 8)
- CNT_W, 16, width of each statistics counter
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  branch request valid
- ready_o  out  1  block can accept a request this cycle
- br_op_i  in  3  RISC-V funct3 of the branch
- rs1_data_i, rs2_data_i  in  XLEN  operands
- pc_i  in  XLEN  PC of the branch
- imm_i  in  XLEN  sign-extended B-immediate
- pred_taken_i  in  1  fetch-stage prediction
- flush_i  in  1  kill the held result and any incoming request
- clr_cnt_i  in  1  clear statistics counters
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts the result
- taken_o, mispredict_o, illegal_o  out  1  resolved direction, prediction mismatch, unsupported funct3
- br_less_o, br_equal_o  out  1  raw compare flags
- redirect_pc_o  out  XLEN  target if taken, otherwise PC+4
- br_cnt_o, mis_cnt_o  out  CNT_W  retired branches and retired mispredicts

## Operation
- Flags: br_equal = (rs1 == rs2).
- br_less is an unsigned compare for funct3 110 and 111, and a signed compare for every other funct3.
- funct3 decode:
  - 000 BEQ: taken = equal
  - 001 BNE: taken = !equal
  - 100 BLT: taken = less
  - 101 BGE: taken = !less
  - 110 BLTU: taken = less
  - 111 BGEU: taken = !less
  - 010 and 011: taken = 0, illegal = 1, mispredict = pred_taken_i
- Target is pc_i + imm_i and fall-through is pc_i + 4. Both are computed modulo 2^XLEN and wrap silently.
- mispredict = taken XOR pred_taken_i.
- Accept occurs when valid_i && ready_o && !flush_i. On accept, all result fields are registered and valid_o is set.
- ready_o = !valid_o || ready_i. This is combinational and independent of valid_i.
- Retire occurs when valid_o && ready_i && !flush_i.
  - Retire clears valid_o unless a new request is accepted in the same cycle.
  - Retire increments br_cnt. It also increments mis_cnt when mispredict_o = 1.
- flush_i clears valid_o next cycle, discards any incoming request, and blocks counting. It has priority over accept and retire.
- Counters saturate at all-ones.
  - clr_cnt_i zeroes both counters and has priority over a same-cycle increment.
- Illegal ops are retired and counted as branches like any other op.

## Timing
- Reset: valid_o = 0, every data output = 0, both counters = 0, ready_o = 1.
- Latency is one cycle, from the accept edge to valid_o high.
- Throughput is one result per cycle while ready_i is high.
- Back-pressure: while valid_o && !ready_i, every output stays stable and ready_o = 0.
- The raw flags and redirect fields are registered copies and change only on accept.
- Reset asserted while a result is held drops it, with no count.
- Reset has priority over flush_i and clr_cnt_i.

## Structure
- Package br_pkg holds:
  - br_op_e enum, with the six funct3 encodings plus an illegal default
  - a default XLEN localparam
  - a result struct of taken, mispredict, illegal, less, equal and redirect_pc
- Sub-module br_cmp is the combinational XLEN-parametrised comparator. It takes rs1, rs2 and an unsigned select, and produces less and equal.
- br_resolve instantiates br_cmp, the decode, the adders, the output register and the counters.

## Test plan
- BLT signed, rs1 = 0xFFFF_FFFF, rs2 = 0x0000_0001, pc = 0x100, imm = 0x20, pred = 0. Required: next cycle valid_o = 1, taken = 1, less = 1, redirect = 0x120, mispredict = 1.
- BLTU with the same operands and pred = 0. Required: taken = 0, less = 0, redirect = 0x104, mispredict = 0.
- Back-pressure: hold ready_i = 0 for 3 cycles while valid_i is held with a new request. Required: outputs stay frozen, ready_o = 0, and counters do not move. Release ready_i; the second result appears the following cycle and br_cnt = 1.
- Wrap: pc = 0xFFFF_FFFC, imm = 0x8, BEQ with equal operands. Required: redirect = 0x0000_0004. Not-taken fall-through gives 0x0000_0000.
- flush_i asserted with valid_o = 1 and ready_i = 1, while valid_i is also high. Required: next cycle valid_o = 0 and counters unchanged.
- CNT_W = 2:
  - retire 5 mispredicting branches → br_cnt = mis_cnt = 3
  - assert clr_cnt_i with a retiring branch → both counters = 0
  - funct3 = 010 → illegal_o = 1, taken = 0
